trng_wb_master: RTL and testbench

TRNG_WB_MASTER -- requirements
Module: trng_wb_master

---
 rtl/trng_pkg.sv | 26 ++
 rtl/wb_ack_timer.sv | 31 +++
 rtl/trng_wb_master.sv | 164 ++++++++++++++++
 tb/tb_trng_wb_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG-to-SRAM Wishbone fill engine.
// Holds the FSM state encoding, the TRNG register map and the datapath widths.
package trng_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;

    localparam logic [ADDR_W-1:0] TRNG_STATUS_ADDR = 9'h000;
    localparam logic [ADDR_W-1:0] TRNG_DATA_ADDR   = 9'h004;
    localparam logic [CNT_W-1:0]  MAX_WORDS        = 10'd512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    // The SRAM holds 512 words, so larger requests are clamped to a full fill.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] count);
        return (count > MAX_WORDS) ? MAX_WORDS : count;
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Counts consecutive strobe cycles without an acknowledge.
// expired is raised in the LIMIT-th such cycle, unless an ack arrives in that same cycle.
module wb_ack_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/trng_wb_master.sv
// Wishbone initiator that polls a TRNG, reads random words and writes them into
// consecutive SRAM locations starting at a caller-supplied base address.
module trng_wb_master
    import trng_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STATUS_ADDR = TRNG_STATUS_ADDR,
    parameter logic [ADDR_W-1:0] DATA_ADDR   = TRNG_DATA_ADDR,
    parameter int                ACK_TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              rst_ni,

    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,

    output logic              trng_wb_cyc_o,
    output logic              trng_wb_stb_o,
    output logic [ADDR_W-1:0] trng_wb_adr_o,
    output logic              trng_wb_we_o,
    output logic [DATA_W-1:0] trng_wb_dat_o,
    input  logic [DATA_W-1:0] trng_wb_dat_i,
    input  logic              trng_wb_ack_i,

    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [3:0]        sram_mask_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_din_o
);

    state_t            state, state_next;
    logic              gap;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic              stb;
    logic              ack_acc;
    logic              start_ok;
    logic              timer_clear;
    logic              expired;

    assign ack_acc     = stb & trng_wb_ack_i;
    assign start_ok    = (state == ST_IDLE) & start_i;
    assign timer_clear = !stb || trng_wb_ack_i;

    wb_ack_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (wb_clk_i),
        .rst_n   (rst_ni),
        .clear   (timer_clear),
        .enable  (stb),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = (count_i == '0) ? ST_DONE : ST_POLL;
                end
            end
            ST_POLL: begin
                if (ack_acc) begin
                    state_next = trng_wb_dat_i[0] ? ST_READ : ST_POLL;
                end else if (expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_READ: begin
                if (ack_acc) begin
                    state_next = ST_WRITE;
                end else if (expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_WRITE: state_next = (remaining == CNT_W'(1)) ? ST_DONE : ST_POLL;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        stb         = 1'b0;
        trng_wb_adr_o = '0;
        sram_csb_o  = 1'b1;
        sram_web_o  = 1'b1;
        sram_mask_o = 4'h0;
        case (state)
            ST_POLL: begin
                stb           = !gap;
                trng_wb_adr_o = STATUS_ADDR;
            end
            ST_READ: begin
                stb           = !gap;
                trng_wb_adr_o = DATA_ADDR;
            end
            ST_WRITE: begin
                sram_csb_o  = 1'b0;
                sram_web_o  = 1'b0;
                sram_mask_o = 4'hF;
            end
            default: ;
        endcase
    end

    assign trng_wb_cyc_o = stb;
    assign trng_wb_stb_o = stb;
    assign trng_wb_we_o  = 1'b0;
    assign trng_wb_dat_o = '0;
    assign busy_o        = (state != ST_IDLE);
    assign done_o        = (state == ST_DONE);
    assign err_o         = err_q;
    assign sram_addr_o   = sram_addr_q;
    assign sram_din_o    = data_q;

    // gap forces one idle bus cycle after every accepted ack.
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap         <= 1'b0;
            ptr         <= '0;
            remaining   <= '0;
            data_q      <= '0;
            sram_addr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            gap <= ack_acc;
            if (start_ok) begin
                ptr       <= base_addr_i;
                remaining <= sat_count(count_i);
                err_q     <= 1'b0;
            end
            if ((state == ST_READ) && ack_acc) begin
                data_q      <= trng_wb_dat_i;
                sram_addr_q <= ptr;
            end
            if (state == ST_WRITE) begin
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (expired) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trng_wb_master.sv
// Randomized scoreboard bench for trng_wb_master: a TRNG slave model serves
// status/data reads, expected SRAM writes are queued at start and checked by a monitor.
module tb_trng_wb_master;
    import trng_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              wb_clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic [CNT_W-1:0]  count_i = '0;
    logic              busy_o, done_o, err_o;
    logic              trng_wb_cyc_o, trng_wb_stb_o, trng_wb_we_o;
    logic [ADDR_W-1:0] trng_wb_adr_o;
    logic [DATA_W-1:0] trng_wb_dat_o;
    logic [DATA_W-1:0] trng_wb_dat_i = '0;
    logic              trng_wb_ack_i = 1'b0;
    logic              sram_csb_o, sram_web_o;
    logic [3:0]        sram_mask_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_din_o;

    int checks = 0;
    int errors = 0;

    wr_t         exp_q[$];
    logic [31:0] data_q[$];
    bit          status_q[$];

    int wait_cnt = 0, lat = 0, fixed_lat = -1;
    bit no_ack = 0, noise = 0;
    int status_reads = 0, data_reads = 0, stb_run = 0, max_run = 0;
    int done_cnt = 0, exp_done = 0;

    trng_wb_master dut (
        .wb_clk_i      (wb_clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .count_i       (count_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .trng_wb_cyc_o (trng_wb_cyc_o),
        .trng_wb_stb_o (trng_wb_stb_o),
        .trng_wb_adr_o (trng_wb_adr_o),
        .trng_wb_we_o  (trng_wb_we_o),
        .trng_wb_dat_o (trng_wb_dat_o),
        .trng_wb_dat_i (trng_wb_dat_i),
        .trng_wb_ack_i (trng_wb_ack_i),
        .sram_csb_o    (sram_csb_o),
        .sram_web_o    (sram_web_o),
        .sram_mask_o   (sram_mask_o),
        .sram_addr_o   (sram_addr_o),
        .sram_din_o    (sram_din_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // TRNG slave: acks after a per-access latency, answers from scripted queues.
    initial begin
        logic [31:0] word;
        forever begin
            @(negedge wb_clk_i);
            if (trng_wb_stb_o) begin
                stb_run++;
                if (stb_run > max_run) max_run = stb_run;
            end else begin
                stb_run = 0;
            end
            if (trng_wb_ack_i) begin
                trng_wb_ack_i = 1'b0;
                trng_wb_dat_i = '0;
                wait_cnt = 0;
            end else if (trng_wb_stb_o && rst_ni && !no_ack) begin
                if (wait_cnt >= lat) begin
                    trng_wb_ack_i = 1'b1;
                    if (trng_wb_adr_o == TRNG_STATUS_ADDR) begin
                        status_reads++;
                        word = $urandom;
                        word[0] = (status_q.size() > 0) ? status_q.pop_front() : 1'b1;
                    end else begin
                        data_reads++;
                        word = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
                    end
                    trng_wb_dat_i = word;
                    wait_cnt = 0;
                    lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
                end else begin
                    wait_cnt++;
                end
            end else if (!trng_wb_stb_o) begin
                wait_cnt = 0;
                if (noise && ($urandom_range(0, 1) == 1)) begin
                    trng_wb_ack_i = 1'b1;
                    trng_wb_dat_i = 32'h1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every SRAM write and checks bus invariants.
    initial begin
        wr_t e;
        logic prev_csb;
        prev_csb = 1'b1;
        forever begin
            @(negedge wb_clk_i);
            if (done_o) done_cnt++;
            if (trng_wb_stb_o) begin
                check("wb_we_zero", trng_wb_we_o, 0);
                check("wb_dat_o_zero", trng_wb_dat_o, 0);
                check("wb_cyc_with_stb", trng_wb_cyc_o, 1);
            end
            if (!sram_csb_o) begin
                check("sram_single_cycle", prev_csb, 1);
                check("sram_write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sram_addr", sram_addr_o, e.addr);
                    check("sram_din", sram_din_o, e.data);
                    check("sram_mask", sram_mask_o, 4'hF);
                    check("sram_web", sram_web_o, 0);
                end
            end
            prev_csb = sram_csb_o;
        end
    end

    task automatic run_fill(input logic [ADDR_W-1:0] base, input int cnt, input bit poke, input bit to);
        int n, zeros, budget;
        bit seen;
        logic [31:0] w;
        n = (cnt > 512) ? 512 : cnt;
        zeros = status_q.size();
        status_reads = 0;
        data_reads = 0;
        max_run = 0;
        if (!to) begin
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                data_q.push_back(w);
                exp_q.push_back('{addr: ADDR_W'((int'(base) + i) % 512), data: w});
            end
        end
        @(negedge wb_clk_i);
        start_i = 1'b1;
        base_addr_i = base;
        count_i = CNT_W'(cnt);
        @(negedge wb_clk_i);
        start_i = 1'b0;
        check("start_stb", trng_wb_stb_o, 1);
        check("start_adr", trng_wb_adr_o, TRNG_STATUS_ADDR);
        check("start_busy", busy_o, 1);
        check("start_err_cleared", err_o, 0);
        if (poke) begin
            repeat (3) @(negedge wb_clk_i);
            start_i = 1'b1;
            base_addr_i = 9'h155;
            count_i = 10'd5;
            @(negedge wb_clk_i);
            start_i = 1'b0;
        end
        budget = 2000 + n * 600;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge wb_clk_i);
            if (done_o) seen = 1;
        end
        check("done_seen", seen, 1);
        exp_done++;
        @(negedge wb_clk_i);
        check("done_one_cycle", done_o, 0);
        check("idle_after_done", busy_o, 0);
        if (to) begin
            check("timeout_stb_cycles", max_run, 255);
            check("timeout_err", err_o, 1);
        end else begin
            check("writes_complete", exp_q.size(), 0);
            check("status_reads", status_reads, n + zeros);
            check("data_reads", data_reads, n);
            check("no_err", err_o, 0);
        end
        exp_q.delete();
        data_q.delete();
        status_q.delete();
    endtask

    initial begin
        int bad;
        // Reset values
        repeat (3) @(negedge wb_clk_i);
        check("rst_cyc", trng_wb_cyc_o, 0);
        check("rst_stb", trng_wb_stb_o, 0);
        check("rst_adr", trng_wb_adr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_csb", sram_csb_o, 1);
        check("rst_web", sram_web_o, 1);
        check("rst_mask", sram_mask_o, 0);
        check("rst_sram_addr", sram_addr_o, 0);
        check("rst_sram_din", sram_din_o, 0);
        rst_ni = 1'b1;

        // Three words at 0x010, ack one cycle after stb
        fixed_lat = 1; lat = 1;
        run_fill(9'h010, 3, 0, 0);
        fixed_lat = -1;

        // Status not ready twice before a single word
        status_q.push_back(0); status_q.push_back(0);
        run_fill(ADDR_W'($urandom), 1, 0, 0);

        // Pointer wrap
        run_fill(9'h1FE, 4, 0, 0);

        // Zero-length request
        @(negedge wb_clk_i);
        start_i = 1'b1; count_i = '0; base_addr_i = 9'h0AA;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        check("zero_done", done_o, 1);
        check("zero_cyc", trng_wb_cyc_o, 0);
        check("zero_csb", sram_csb_o, 1);
        exp_done++;
        @(negedge wb_clk_i);
        check("zero_done_pulse", done_o, 0);
        check("zero_idle", busy_o, 0);

        // start while busy is ignored
        run_fill(ADDR_W'($urandom), 8, 1, 0);

        // Spurious acks while stb is low
        noise = 1;
        run_fill(ADDR_W'($urandom), 6, 0, 0);
        noise = 0;

        // Random fills with random not-ready status runs
        for (int k = 0; k < 4; k++) begin
            int sc;
            sc = $urandom_range(0, 2);
            for (int j = 0; j < sc; j++) status_q.push_back(0);
            run_fill(ADDR_W'($urandom), $urandom_range(1, 20), 0, 0);
        end

        // Oversized request saturates to 512 words
        run_fill(ADDR_W'($urandom), 700, 0, 0);

        // Ack in the very cycle the timeout would fire
        fixed_lat = 254; lat = 254;
        run_fill(ADDR_W'($urandom), 1, 0, 0);
        fixed_lat = -1; lat = 0;

        // Ack never returned
        no_ack = 1;
        run_fill(ADDR_W'($urandom), 2, 0, 1);
        no_ack = 0;
        repeat (3) @(negedge wb_clk_i);
        check("err_sticky", err_o, 1);
        run_fill(ADDR_W'($urandom), 2, 0, 0);

        // Reset in the middle of a READ
        fixed_lat = 3; lat = 3;
        for (int i = 0; i < 3; i++) data_q.push_back($urandom);
        @(negedge wb_clk_i);
        start_i = 1'b1; base_addr_i = 9'h033; count_i = 10'd3;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        bad = 1;
        for (int c = 0; c < 200 && bad == 1; c++) begin
            @(negedge wb_clk_i);
            if (trng_wb_stb_o && (trng_wb_adr_o == TRNG_DATA_ADDR)) bad = 0;
        end
        check("reached_read", bad, 0);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_cyc", trng_wb_cyc_o, 0);
        check("midrst_stb", trng_wb_stb_o, 0);
        check("midrst_csb", sram_csb_o, 1);
        check("midrst_busy", busy_o, 0);
        repeat (3) @(negedge wb_clk_i);
        check("midrst_no_write", sram_csb_o, 1);
        rst_ni = 1'b1;
        data_q.delete();
        fixed_lat = -1;

        // Recovery after reset
        run_fill(ADDR_W'($urandom), 5, 0, 0);
        repeat (5) @(negedge wb_clk_i);
        check("done_pulses_total", done_cnt, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
